// File: rtl/uart_tx_scheduler_pkg.sv
// Shared UART definitions: debug state encodings for the TX scheduler and the
// receiver, the default payload width and a small one-hot helper.
package uart_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    LAUNCH      = 2'd1,
    WAIT_ACCEPT = 2'd2,
    WAIT_DONE   = 2'd3
  } tx_sched_state_e;

  // Receiver encodings live here too so every UART block reports state alike.
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  function automatic logic [2:0] oneHotToIdx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Requester and transmitter side signals of the UART TX scheduler; the
// scheduler uses the slave view, the environment the master view.
interface uart_tx_scheduler_if
  import uart_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = DATA_W_DEF
);

  logic [N_REQ-1:0]        in_valid;
  logic [N_REQ*DATA_W-1:0] in_data;
  logic [N_REQ-1:0]        in_ready;
  logic                    tx_ready;
  logic                    tx_start;
  logic [DATA_W-1:0]       tx_data;
  logic [N_REQ-1:0]        grant;
  logic                    busy;
  logic [1:0]              state;

  modport master (
    output in_valid, in_data, tx_ready,
    input  in_ready, tx_start, tx_data, grant, busy, state
  );

  modport slave (
    input  in_valid, in_data, tx_ready,
    output in_ready, tx_start, tx_data, grant, busy, state
  );

endinterface

// File: rtl/uart_tx_scheduler_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i,
// wrapping, returned one-hot.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PW-1:0]    ptr_i,
  output logic [N_REQ-1:0] winner_o,
  output logic             any_o
);

  logic [N_REQ-1:0] reqRot;
  logic [N_REQ-1:0] winRot;

  // Rotate so ptr_i sits at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    reqRot   = N_REQ'({req_i, req_i} >> ptr_i);
    winRot   = reqRot & (~reqRot + N_REQ'(1));
    winner_o = N_REQ'(({winRot, winRot} << ptr_i) >> N_REQ);
  end

  assign any_o = |req_i;

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter between N_REQ requesters with round-robin
// grants and a per-owner burst cap.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               reset,
  uart_tx_scheduler_if.slave bus
);

  localparam int              PW        = $clog2(N_REQ);
  localparam int              BW        = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0]   BURST_MAX = BW'(MAX_BURST);
  localparam logic [PW-1:0]   LAST_REQ  = PW'(N_REQ - 1);

  tx_sched_state_e   state_q, state_d;
  logic [PW-1:0]     rrPtr_q, rrPtr_d;
  logic [BW-1:0]     burstCnt_q, burstCnt_d;
  logic [DATA_W-1:0] txData_q, txData_d;
  logic              txStart_q, txStart_d;
  logic [N_REQ-1:0]  grant_q, grant_d;

  logic [N_REQ-1:0]  winner;
  logic [N_REQ-1:0]  sel;
  logic [N_REQ-1:0]  inReady;
  logic              anyValid;
  logic [DATA_W-1:0] selData;
  logic [PW-1:0]     ownerIdx;

  rr_pick #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) uPick (
    .req_i    (bus.in_valid),
    .ptr_i    (rrPtr_q),
    .winner_o (winner),
    .any_o    (anyValid)
  );

  // A new owner is chosen only from IDLE; afterwards the held grant selects.
  assign sel      = (state_q == IDLE) ? winner : grant_q;
  assign ownerIdx = PW'(oneHotToIdx(8'(grant_q)));

  always_comb begin
    selData = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (sel[i]) selData = selData | bus.in_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d    = state_q;
    rrPtr_d    = rrPtr_q;
    burstCnt_d = burstCnt_q;
    txData_d   = txData_q;
    txStart_d  = 1'b0;
    grant_d    = grant_q;
    inReady    = '0;
    case (state_q)
      IDLE: begin
        if (bus.tx_ready && anyValid) begin
          inReady    = winner;
          txData_d   = selData;
          grant_d    = winner;
          burstCnt_d = BW'(1);
          txStart_d  = 1'b1;
          state_d    = LAUNCH;
        end
      end
      LAUNCH: state_d = WAIT_ACCEPT;
      WAIT_ACCEPT: begin
        if (!bus.tx_ready) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        // Frame-complete cycle doubles as the accept cycle of the next burst byte.
        if (bus.tx_ready) begin
          if ((|(bus.in_valid & grant_q)) && (burstCnt_q < BURST_MAX)) begin
            inReady    = grant_q;
            txData_d   = selData;
            burstCnt_d = burstCnt_q + BW'(1);
            txStart_d  = 1'b1;
            state_d    = LAUNCH;
          end else begin
            rrPtr_d    = (ownerIdx == LAST_REQ) ? '0 : ownerIdx + PW'(1);
            grant_d    = '0;
            burstCnt_d = '0;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      rrPtr_q    <= '0;
      burstCnt_q <= '0;
      txData_q   <= '0;
      txStart_q  <= 1'b0;
      grant_q    <= '0;
    end else begin
      state_q    <= state_d;
      rrPtr_q    <= rrPtr_d;
      burstCnt_q <= burstCnt_d;
      txData_q   <= txData_d;
      txStart_q  <= txStart_d;
      grant_q    <= grant_d;
    end
  end

  // A requester must never see in_ready for a byte that reset throws away.
  assign bus.in_ready = reset ? inReady : '0;
  assign bus.tx_start = txStart_q;
  assign bus.tx_data  = txData_q;
  assign bus.grant    = grant_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.state    = state_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench: expected (requester, byte) launches are queued as traffic
// is offered and popped on every tx_start.
module tb_uart_tx_scheduler;
  import uart_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rstN;
  always #5 clk = ~clk;

  logic [N-1:0]    inValid;
  logic [N*DW-1:0] inData;
  logic            txReady;
  bit              useB;

  uart_tx_scheduler_if #(.N_REQ(N), .DATA_W(DW)) busA ();
  uart_tx_scheduler_if #(.N_REQ(N), .DATA_W(DW)) busB ();

  assign busA.in_valid = inValid;
  assign busA.in_data  = inData;
  assign busA.tx_ready = txReady;
  assign busB.in_valid = inValid;
  assign busB.in_data  = inData;
  assign busB.tx_ready = txReady;

  uart_tx_scheduler #(.N_REQ(N), .DATA_W(DW), .MAX_BURST(4)) dutA (
    .clk   (clk),
    .reset (rstN),
    .bus   (busA)
  );

  uart_tx_scheduler #(.N_REQ(N), .DATA_W(DW), .MAX_BURST(1)) dutB (
    .clk   (clk),
    .reset (rstN),
    .bus   (busB)
  );

  logic [N-1:0]  oInReady, oGrant;
  logic          oTxStart, oBusy;
  logic [DW-1:0] oTxData;
  logic [1:0]    oState;

  always_comb begin
    if (useB) begin
      oInReady = busB.in_ready; oGrant = busB.grant; oTxStart = busB.tx_start;
      oBusy = busB.busy; oTxData = busB.tx_data; oState = busB.state;
    end else begin
      oInReady = busA.in_ready; oGrant = busA.grant; oTxStart = busA.tx_start;
      oBusy = busA.busy; oTxData = busA.tx_data; oState = busA.state;
    end
  end

  int checks;
  int errors;
  int sbQ[$];

  int         remaining[N];
  int         sent[N];
  int         pulses[N];
  logic [7:0] base[N];
  logic [N-1:0] readySeen;
  bit         prevAccept;

  int latCnt, frameCnt, txLat, frameLen;
  bit txBusy, txHold;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  function automatic void refreshInputs();
    for (int i = 0; i < N; i++) begin
      inValid[i]         = (remaining[i] > 0);
      inData[i*DW +: DW] = base[i] + 8'(sent[i]);
    end
  endfunction

  function automatic void resetModels();
    for (int i = 0; i < N; i++) begin
      remaining[i] = 0; sent[i] = 0; pulses[i] = 0; base[i] = 8'h00;
    end
    readySeen = '0; prevAccept = 1'b0;
    latCnt = 0; frameCnt = 0; txBusy = 1'b0; txHold = 1'b0;
    sbQ.delete();
    txReady = 1'b1;
    refreshInputs();
  endfunction

  task automatic applyStimulus(input int id, input int nBytes, input logic [7:0] baseByte);
    base[id]      = baseByte;
    remaining[id] = nBytes;
    sent[id]      = 0;
    pulses[id]    = 0;
    refreshInputs();
  endtask

  function automatic void expectByte(input int id, input int k);
    logic [7:0] d;
    d = base[id] + 8'(k);
    sbQ.push_back(id * 256 + int'(d));
  endfunction

  task automatic sampleOutputs();
    int exp;
    readySeen = oInReady;
    if (oInReady != '0) begin
      checkOutput("inReadyOneHot", $onehot(oInReady), 1);
      checkOutput("inReadyOnlyValid", oInReady & ~inValid, 0);
    end
    if (oTxStart) begin
      checkOutput("startLatency", prevAccept, 1);
      checkOutput("busyInLaunch", oBusy, 1);
      checkOutput("sbNotEmptyAtStart", (sbQ.size() > 0), 1);
      if (sbQ.size() > 0) begin
        exp = sbQ.pop_front();
        checkOutput("txData", oTxData, exp % 256);
        checkOutput("grantOwner", oGrant, 32'(1) << (exp / 256));
      end
      latCnt = txLat;
    end
    prevAccept = (oInReady != '0);
  endtask

  function automatic void advanceModels();
    for (int i = 0; i < N; i++) begin
      if (readySeen[i]) begin
        sent[i]++; remaining[i]--; pulses[i]++;
      end
    end
    readySeen = '0;
    if (latCnt > 0) begin
      latCnt--;
      if (latCnt == 0) begin
        txBusy = 1'b1; frameCnt = frameLen;
      end
    end else if (frameCnt > 0) begin
      frameCnt--;
      if (frameCnt == 0) txBusy = 1'b0;
    end
    txReady = !txBusy && !txHold;
    refreshInputs();
  endfunction

  task automatic tick();
    @(negedge clk);
    sampleOutputs();
    @(posedge clk);
    #1;
    advanceModels();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (!(sbQ.size() == 0 && inValid == '0 && !txBusy && latCnt == 0 && oState == 2'd0)
           && n < budget) begin
      tick();
      n++;
    end
    checkOutput("drainInTime", (n < budget), 1);
    checkOutput("idleAfterDrain", {oBusy, oGrant, oState}, 0);
  endtask

  task automatic pulseReset();
    rstN = 1'b0;
    resetModels();
    @(posedge clk);
    #1 rstN = 1'b1;
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    checks = 0; errors = 0; useB = 1'b0;
    txLat = 1; frameLen = 10;
    rstN = 1'b0;
    resetModels();
    for (int i = 0; i < N; i++) applyStimulus(i, 1, 8'hC0);
    #2;
    checkOutput("resetOutputs", {oState, oBusy, oGrant, oTxStart, oTxData, oInReady}, 0);
    resetModels();
    @(posedge clk);
    #1 rstN = 1'b1;

    $display("[TB] single requester");
    applyStimulus(0, 1, 8'hA5);
    expectByte(0, 0);
    #1;
    checkOutput("singleInReady", oInReady, 4'b0001);
    drain(100);

    $display("[TB] burst cap");
    applyStimulus(1, 1, 8'h10);
    expectByte(1, 0);
    drain(100);
    txLat = 2;
    applyStimulus(2, 6, 8'h20);
    applyStimulus(0, 1, 8'h30);
    for (int k = 0; k < 4; k++) expectByte(2, k);
    expectByte(0, 0);
    expectByte(2, 4);
    expectByte(2, 5);
    drain(400);
    checkOutput("burstPulses2", pulses[2], 6);
    checkOutput("burstPulses0", pulses[0], 1);
    txLat = 1;

    $display("[TB] early end");
    applyStimulus(3, 1, 8'h40);
    expectByte(3, 0);
    drain(100);
    applyStimulus(1, 1, 8'h50);
    applyStimulus(0, 1, 8'h60);
    expectByte(0, 0);
    expectByte(1, 0);
    drain(200);

    $display("[TB] blocked transmitter");
    txHold = 1'b1;
    txReady = 1'b0;
    for (int i = 0; i < N; i++) applyStimulus(i, 1, 8'(8'h80 + i));
    for (int c = 0; c < 5; c++) begin
      tick();
      checkOutput("blockedInReady", oInReady, 0);
      checkOutput("blockedState", oState, 0);
    end
    expectByte(2, 0); expectByte(3, 0); expectByte(0, 0); expectByte(1, 0);
    txHold = 1'b0;
    txReady = 1'b1;
    #1;
    checkOutput("unblockGrant", oInReady, 4'b0100);
    drain(400);

    $display("[TB] reset mid-frame");
    applyStimulus(1, 3, 8'h70);
    expectByte(1, 0);
    n = 0;
    while (oState != 2'd3 && n < 50) begin
      tick();
      n++;
    end
    checkOutput("reachWaitDone", oState, 3);
    repeat (3) tick();
    #3 rstN = 1'b0;
    #1;
    checkOutput("asyncResetOutputs", {oState, oBusy, oGrant, oTxStart, oTxData}, 0);
    checkOutput("sbEmptyAtReset", sbQ.size(), 0);
    resetModels();
    applyStimulus(1, 1, 8'h90);
    applyStimulus(0, 1, 8'hE0);
    #1;
    checkOutput("inReadyHeldInReset", oInReady, 0);
    expectByte(0, 0);
    expectByte(1, 0);
    @(posedge clk);
    #1 rstN = 1'b1;
    #1;
    checkOutput("postResetPriority", oInReady, 4'b0001);
    drain(200);

    $display("[TB] fairness with single-byte bursts");
    useB = 1'b1;
    pulseReset();
    for (int i = 0; i < N; i++) applyStimulus(i, 2, 8'(i * 16));
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) expectByte(i, r);
    drain(600);
    for (int i = 0; i < N; i++) checkOutput("fairPulses", pulses[i], 2);

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
